// File: rtl/hbm_rd_lat_engine_if.sv
// AXI3 read address/data channel bundle between the read engine and one HBM pseudo-channel.
// The engine owns the AR channel and R-channel ready; the memory side owns arready and the R beat.
interface hbm_rd_lat_engine_if;
    logic [33:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [5:0]  arid;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic [1:0]  rresp;
    logic        rready;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // once valid is raised the sender holds it and its payload stable until that edge.
    modport master (
        output araddr, arlen, arsize, arburst, arid, arvalid, rready,
        input  arready, rvalid, rlast, rresp
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arvalid, rready,
        output arready, rvalid, rlast, rresp
    );
endinterface

// File: rtl/hbm_rd_lat_engine.sv
// Per-channel HBM read traffic generator: latency sampling or throughput runs from one lt_params word.
// Optional macro LAT_ENGINE_RESP_CHECK_EN enables counting of non-OKAY read beats on err_cnt.
module hbm_rd_lat_engine #(
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic                       hbm_clk,
    input  logic                       hbm_rst,
    input  logic [511:0]               lt_params,
    input  logic                       start,
    hbm_rd_lat_engine_if.master        m_axi,
    output logic                       lat_timer_valid,
    output logic [15:0]                lat_timer,
    output logic                       busy,
    output logic                       done,
    output logic [63:0]                total_cycles,
    output logic [31:0]                err_cnt,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] MAX_OUT = MAX_OUTSTANDING[7:0];

    state_t      state_q, state_nxt;

    logic [31:0] wgs_q;
    logic [31:0] stride_q;
    logic [63:0] num_ops_q;
    logic [26:0] burst_units_q;
    logic [33:0] init_q;
    logic        lat_en_q;
    logic [4:0]  chan_q;

    logic [31:0] offset_q;
    logic [63:0] issued_q;
    logic [63:0] completed_q;
    logic [7:0]  outstanding_q;
    logic        arvalid_q;
    logic [15:0] timer_q;
    logic [15:0] lat_timer_q;
    logic        lat_valid_q;
    logic [63:0] run_cnt_q;
    logic [63:0] last_total_q;
    logic [63:0] total_q;
    logic        done_q;

    logic        busy_c;
    logic        ar_hs;
    logic        r_last_beat;
    logic        last_op;
    logic        out_dec;
    logic [7:0]  outstanding_nxt;
    logic [63:0] issued_nxt;
    logic        arvalid_nxt;
    logic [32:0] off_sum;
    logic [31:0] off_nxt;
    logic [4:0]  beats_c;
    logic [4:0]  len_m1;
    logic [15:0] timer_inc;
    logic        lat_capture;

    assign busy_c      = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign ar_hs       = arvalid_q && m_axi.arready;
    // R beats outside a run are accepted (rready is constant) but never counted.
    assign r_last_beat = m_axi.rvalid && m_axi.rlast && busy_c;
    assign last_op     = ((completed_q + 64'd1) == num_ops_q);
    assign out_dec     = r_last_beat && (outstanding_q != 8'd0);
    assign outstanding_nxt = outstanding_q + {7'd0, ar_hs} - {7'd0, out_dec};
    assign issued_nxt  = issued_q + {63'd0, ar_hs};

    // Offset walks by stride inside a wgs-sized window; the sum is 33 bits so it cannot alias.
    assign off_sum = {1'b0, offset_q} + {1'b0, stride_q};
    assign off_nxt = ((wgs_q == 32'd0) || (off_sum >= {1'b0, wgs_q})) ? 32'd0 : off_sum[31:0];

    always_comb begin
        beats_c = burst_units_q[4:0];
        if (burst_units_q == 27'd0) begin
            beats_c = 5'd1;
        end else if (burst_units_q > 27'd16) begin
            beats_c = 5'd16;
        end
    end

    assign len_m1    = beats_c - 5'd1;
    assign timer_inc = (timer_q == 16'hFFFF) ? 16'hFFFF : (timer_q + 16'd1);
    assign lat_capture = r_last_beat && lat_en_q && (state_q == S_WAIT);

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (num_ops_q == 64'd0) begin
                    state_nxt = S_DONE;
                end else if (ar_hs) begin
                    if (lat_en_q) begin
                        state_nxt = S_WAIT;
                    end else if (issued_nxt == num_ops_q) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_WAIT:  if (r_last_beat) state_nxt = last_op ? S_DONE : S_ISSUE;
            S_DRAIN: if (completed_q == num_ops_q) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // arvalid may go back-to-back in throughput mode when the window still has room.
    always_comb begin
        arvalid_nxt = 1'b0;
        if (arvalid_q && !m_axi.arready) begin
            arvalid_nxt = 1'b1;
        end else if ((state_q == S_ISSUE) && (state_nxt == S_ISSUE) && (issued_nxt < num_ops_q)) begin
            arvalid_nxt = lat_en_q || (outstanding_nxt < MAX_OUT);
        end
    end

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            wgs_q         <= '0;
            stride_q      <= '0;
            num_ops_q     <= '0;
            burst_units_q <= '0;
            init_q        <= '0;
            lat_en_q      <= 1'b0;
            chan_q        <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            wgs_q         <= lt_params[31:0];
            stride_q      <= lt_params[63:32];
            num_ops_q     <= lt_params[127:64];
            burst_units_q <= lt_params[159:133];
            init_q        <= lt_params[193:160];
            lat_en_q      <= lt_params[224];
            chan_q        <= lt_params[229:225];
        end
    end

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            offset_q      <= '0;
            issued_q      <= '0;
            completed_q   <= '0;
            outstanding_q <= '0;
            run_cnt_q     <= '0;
            last_total_q  <= '0;
        end else if (state_q == S_LOAD) begin
            offset_q      <= '0;
            issued_q      <= '0;
            completed_q   <= '0;
            outstanding_q <= '0;
            run_cnt_q     <= '0;
            last_total_q  <= '0;
        end else begin
            if (ar_hs) begin
                offset_q <= off_nxt;
            end
            issued_q      <= issued_nxt;
            outstanding_q <= outstanding_nxt;
            if (r_last_beat) begin
                completed_q <= completed_q + 64'd1;
            end
            if (busy_c) begin
                run_cnt_q <= run_cnt_q + 64'd1;
            end
            // The final rlast cycle itself is part of the run length.
            if (r_last_beat && last_op) begin
                last_total_q <= run_cnt_q + 64'd1;
            end
        end
    end

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            arvalid_q <= 1'b0;
        end else begin
            arvalid_q <= arvalid_nxt;
        end
    end

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            timer_q     <= '0;
            lat_timer_q <= '0;
            lat_valid_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                timer_q <= 16'd0;
            end else if (timer_q != 16'hFFFF) begin
                timer_q <= timer_q + 16'd1;
            end
            lat_valid_q <= lat_capture;
            if (lat_capture) begin
                lat_timer_q <= timer_inc;
            end
        end
    end

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            done_q  <= 1'b0;
            total_q <= '0;
        end else begin
            done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                total_q <= last_total_q;
            end
        end
    end

`ifdef LAT_ENGINE_RESP_CHECK_EN
    logic [31:0] err_q;

    always_ff @(posedge hbm_clk) begin
        if (hbm_rst) begin
            err_q <= '0;
        end else if (state_q == S_LOAD) begin
            err_q <= '0;
        end else if (busy_c && m_axi.rvalid && (m_axi.rresp != 2'b00) && (err_q != 32'hFFFF_FFFF)) begin
            err_q <= err_q + 32'd1;
        end
    end

    assign err_cnt = err_q;

    logic unused_ok;
    assign unused_ok = ^{lt_params[511:230], lt_params[223:194], lt_params[132:128]};
`else
    assign err_cnt = '0;

    logic unused_ok;
    assign unused_ok = ^{lt_params[511:230], lt_params[223:194], lt_params[132:128], m_axi.rresp};
`endif

    assign m_axi.araddr  = init_q + {2'b00, offset_q};
    assign m_axi.arlen   = len_m1[3:0];
    assign m_axi.arsize  = 3'b101;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arid    = {1'b0, chan_q};
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = 1'b1;

    assign lat_timer_valid = lat_valid_q;
    assign lat_timer       = lat_timer_q;
    assign busy            = busy_c;
    assign done            = done_q;
    assign total_cycles    = total_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_hbm_rd_lat_engine.sv
// Scoreboard bench for hbm_rd_lat_engine: directed scenarios plus randomized runs against a
// transaction-level model of address generation, latency samples and run length.
module tb_hbm_rd_lat_engine;
  localparam int MAX_OUT = 4;

  logic         hbm_clk = 1'b0;
  logic         hbm_rst;
  logic         start;
  logic [511:0] lt_params;
  logic         lat_timer_valid;
  logic [15:0]  lat_timer;
  logic         busy;
  logic         done;
  logic [63:0]  total_cycles;
  logic [31:0]  err_cnt;
  logic [2:0]   dbg_state;

  hbm_rd_lat_engine_if axi();

  hbm_rd_lat_engine #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .hbm_clk(hbm_clk),
    .hbm_rst(hbm_rst),
    .lt_params(lt_params),
    .start(start),
    .m_axi(axi),
    .lat_timer_valid(lat_timer_valid),
    .lat_timer(lat_timer),
    .busy(busy),
    .done(done),
    .total_cycles(total_cycles),
    .err_cnt(err_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle index ----------------
  always #5 hbm_clk = ~hbm_clk;

  int cyc = 0;
  initial forever begin
    @(posedge hbm_clk);
    cyc++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;

  logic [43:0] exp_ar_q[$];    // {arid, arlen, araddr}
  logic [15:0] exp_lat_q[$];
  logic [95:0] exp_done_q[$];  // {err_cnt, total_cycles}

  typedef struct {
    int h;
    int due;
    int beats;
  } pend_t;
  pend_t pend_q[$];

  int hs_cnt = 0;
  int done_cnt = 0;
  int lat_cnt = 0;
  bit hold_r = 1'b0;
  bit rdy_rand = 1'b0;
  int run_delay = 11;
  int run_num_ops = 0;
  bit run_lat_en = 1'b0;
  int start_edge = 0;
  int rlast_sent = 0;
  int err_sent = 0;
  int err_force = 0;
  int err_pct = 0;

  task automatic check_eq(input string name, input logic [95:0] act, input logic [95:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  task automatic note_fail(input string name, input logic [63:0] act);
    n_total++;
    $display("FAIL %s: actual=0x%0h required=none pending", name, act);
  endtask

  function automatic logic [31:0] exp_err(input int sent);
`ifdef LAT_ENGINE_RESP_CHECK_EN
    return 32'(sent);
`else
    return 32'd0 + 32'(sent & 0);
`endif
  endfunction

  // ---------------- reference model ----------------
  function automatic int beats_of(input logic [31:0] burst);
    int b;
    b = int'(burst / 32);
    if (b < 1) b = 1;
    if (b > 16) b = 16;
    return b;
  endfunction

  task automatic model_run(input logic [63:0] num_ops, input logic [31:0] burst,
                           input logic [31:0] stride, input logic [31:0] wgs,
                           input logic [33:0] init, input logic [4:0] chan);
    logic [63:0] off;
    logic [63:0] nxt;
    logic [63:0] addr;
    logic [3:0]  len;
    off = 0;
    len = 4'(beats_of(burst) - 1);
    for (longint k = 0; k < longint'(num_ops); k++) begin
      addr = (64'(init) + off) & 64'h3_FFFF_FFFF;
      exp_ar_q.push_back({1'b0, chan, len, addr[33:0]});
      nxt = off + 64'(stride);
      if (wgs == 0 || nxt >= 64'(wgs)) off = 0;
      else off = nxt;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_run(input bit lat_en, input logic [63:0] num_ops, input logic [31:0] burst,
                           input logic [31:0] stride, input logic [31:0] wgs,
                           input logic [33:0] init, input logic [4:0] chan,
                           input int delay, input bit use_model);
    if (use_model) model_run(num_ops, burst, stride, wgs, init, chan);
    run_lat_en = lat_en;
    run_num_ops = int'(num_ops);
    run_delay = delay;
    rlast_sent = 0;
    err_sent = 0;
    @(posedge hbm_clk);
    #1;
    lt_params = '0;
    lt_params[31:0] = wgs;
    lt_params[63:32] = stride;
    lt_params[127:64] = num_ops;
    lt_params[159:128] = burst;
    lt_params[193:160] = init;
    lt_params[224] = lat_en;
    lt_params[229:225] = chan;
    start = 1'b1;
    @(posedge hbm_clk);
    #1;
    start_edge = cyc;
    start = 1'b0;
    if (num_ops == 0) exp_done_q.push_back({32'd0, 64'd0});
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge hbm_clk);
      #1;
      n++;
    end
    check_eq({name, "_done_seen"}, 96'(done_cnt - d0), 96'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge hbm_clk);
  endtask

  // ---------------- memory-side responder ----------------
  initial begin
    int e;
    axi.arready = 1'b1;
    axi.rvalid = 1'b0;
    axi.rlast = 1'b0;
    axi.rresp = 2'b00;
    forever begin
      @(posedge hbm_clk);
      #1;
      axi.rvalid = 1'b0;
      axi.rlast = 1'b0;
      axi.rresp = 2'b00;
      axi.arready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      e = cyc + 1;
      if (!hbm_rst && !hold_r && pend_q.size() > 0 && e >= pend_q[0].due - pend_q[0].beats + 1) begin
        axi.rvalid = 1'b1;
        axi.rlast = (pend_q[0].beats == 1);
        if (err_force > 0) begin
          axi.rresp = 2'b10;
          err_force--;
        end else if (int'($urandom_range(0, 99)) < err_pct) begin
          axi.rresp = 2'b10;
        end
        if (axi.rresp != 2'b00) err_sent++;
        pend_q[0].beats--;
        if (pend_q[0].beats == 0) begin
          if (run_lat_en) exp_lat_q.push_back((e - pend_q[0].h > 65535) ? 16'hFFFF : 16'(e - pend_q[0].h));
          void'(pend_q.pop_front());
          rlast_sent++;
          if (rlast_sent == run_num_ops) exp_done_q.push_back({exp_err(err_sent), 64'(e - start_edge - 1)});
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit prev_wait;
    logic [33:0] prev_addr;
    logic [43:0] ea;
    logic [95:0] ed;
    pend_t p;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge hbm_clk);
      if (hbm_rst) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait) begin
          check_eq("ar_hold_valid", 96'(axi.arvalid), 96'd1);
          check_eq("ar_hold_addr", 96'(axi.araddr), 96'(prev_addr));
        end
        if (axi.arvalid && axi.arready) begin
          hs_cnt++;
          check_eq("ar_size_burst", 96'({axi.arsize, axi.arburst}), 96'(5'b10101));
          p.h = cyc + 1;
          p.due = cyc + 1 + run_delay;
          if (exp_ar_q.size() == 0) begin
            note_fail("ar_unexpected", 64'(axi.araddr));
            p.beats = int'(axi.arlen) + 1;
          end else begin
            ea = exp_ar_q.pop_front();
            check_eq("ar_beat", 96'({axi.arid, axi.arlen, axi.araddr}), 96'(ea));
            p.beats = int'(ea[37:34]) + 1;
          end
          pend_q.push_back(p);
        end
        prev_wait = axi.arvalid && !axi.arready;
        prev_addr = axi.araddr;
        if (lat_timer_valid) begin
          lat_cnt++;
          if (exp_lat_q.size() == 0) note_fail("lat_unexpected", 64'(lat_timer));
          else check_eq("lat_timer", 96'(lat_timer), 96'(exp_lat_q.pop_front()));
        end
        if (done) begin
          done_cnt++;
          if (exp_done_q.size() == 0) begin
            note_fail("done_unexpected", total_cycles);
          end else begin
            ed = exp_done_q.pop_front();
            check_eq("total_cycles", 96'(total_cycles), 96'(ed[63:0]));
            check_eq("err_cnt", 96'(err_cnt), 96'(ed[95:64]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int h0;
    int l0;
    int n;
    hbm_rst = 1'b1;
    start = 1'b0;
    lt_params = '0;
    wait_cycles(3);
    #1;
    hbm_rst = 1'b0;
    @(negedge hbm_clk);
    check_eq("reset_outputs",
             96'({axi.arvalid, axi.araddr, busy, done, lat_timer_valid, lat_timer}),
             96'(0));
    check_eq("reset_consts", 96'({axi.arsize, axi.arburst, axi.rready}), 96'(6'b101011));
    check_eq("reset_counters", 96'({total_cycles, err_cnt}), 96'(0));

    // Latency mode reference scenario with fixed 11-cycle read latency.
    l0 = lat_cnt;
    exp_ar_q.push_back({6'd3, 4'd1, 34'h1000});
    exp_ar_q.push_back({6'd3, 4'd1, 34'h1040});
    exp_ar_q.push_back({6'd3, 4'd1, 34'h1000});
    exp_ar_q.push_back({6'd3, 4'd1, 34'h1040});
    start_run(1'b1, 64'd4, 32'd64, 32'd64, 32'd128, 34'h1000, 5'd3, 11, 1'b0);
    check_eq("busy_after_start", 96'(busy), 96'd1);
    wait_done("lat4", 500);
    check_eq("lat4_pulses", 96'(lat_cnt - l0), 96'd4);

    // Throughput window fills to MAX_OUT while R is withheld.
    hold_r = 1'b1;
    h0 = hs_cnt;
    start_run(1'b0, 64'd10, 32'd128, 32'd256, 32'd4096, 34'h2_0000_0000, 5'd7, 8, 1'b1);
    wait_cycles(40);
    @(negedge hbm_clk);
    #1;
    check_eq("window_ar_count", 96'(hs_cnt - h0), 96'(MAX_OUT));
    check_eq("window_arvalid", 96'(axi.arvalid), 96'd0);
    hold_r = 1'b0;
    wait_done("thru10", 1000);
    check_eq("thru10_ar_total", 96'(hs_cnt - h0), 96'd10);

    // Zero-op run finishes immediately without any address traffic.
    h0 = hs_cnt;
    start_run(1'b1, 64'd0, 32'd64, 32'd64, 32'd128, 34'h1000, 5'd1, 11, 1'b1);
    wait_done("zero_ops", 4);
    check_eq("zero_ops_no_ar", 96'(hs_cnt - h0), 96'd0);

    // Reset while waiting for read data.
    d0 = done_cnt;
    h0 = hs_cnt;
    start_run(1'b1, 64'd4, 32'd64, 32'd64, 32'd128, 34'h1000, 5'd3, 11, 1'b1);
    n = 0;
    while (hs_cnt == h0 && n < 50) begin
      @(negedge hbm_clk);
      #1;
      n++;
    end
    check_eq("rst_first_hs", 96'(hs_cnt - h0), 96'd1);
    wait_cycles(3);
    #1;
    hbm_rst = 1'b1;
    pend_q.delete();
    exp_ar_q.delete();
    exp_lat_q.delete();
    exp_done_q.delete();
    run_num_ops = 0;
    @(posedge hbm_clk);
    #1;
    hbm_rst = 1'b0;
    @(negedge hbm_clk);
    check_eq("rst_mid_arvalid_busy", 96'({axi.arvalid, busy}), 96'd0);
    check_eq("rst_mid_total", 96'(total_cycles), 96'd0);
    wait_cycles(20);
    check_eq("rst_mid_no_done", 96'(done_cnt - d0), 96'd0);

    l0 = lat_cnt;
    start_run(1'b1, 64'd4, 32'd64, 32'd64, 32'd128, 34'h1000, 5'd3, 11, 1'b1);
    wait_done("after_rst", 500);
    check_eq("after_rst_pulses", 96'(lat_cnt - l0), 96'd4);

    // Long read latency saturates the timer; a start while busy is ignored.
    d0 = done_cnt;
    h0 = hs_cnt;
    start_run(1'b1, 64'd1, 32'd32, 32'd0, 32'd0, 34'h3_FFFF_FFE0, 5'd31, 70000, 1'b1);
    wait_cycles(100);
    #1;
    lt_params[127:64] = 64'd5;
    start = 1'b1;
    @(posedge hbm_clk);
    #1;
    start = 1'b0;
    wait_done("lat_sat", 72000);
    wait_cycles(10);
    check_eq("lat_sat_done_once", 96'(done_cnt - d0), 96'd1);
    check_eq("lat_sat_single_ar", 96'(hs_cnt - h0), 96'd1);
    check_eq("lat_sat_value", 96'(lat_timer), 96'(16'hFFFF));

    // Error responses on three single-beat bursts.
    err_force = 3;
    start_run(1'b1, 64'd3, 32'd32, 32'd32, 32'd1000, 34'h40, 5'd2, 5, 1'b1);
    wait_done("err3", 500);
`ifdef LAT_ENGINE_RESP_CHECK_EN
    check_eq("err3_count", 96'(err_cnt), 96'd3);
`else
    check_eq("err3_count", 96'(err_cnt), 96'd0);
`endif

    // Randomized runs.
    err_pct = 15;
    for (int r = 0; r < 10; r++) begin
      logic [31:0] burst;
      bit le;
      le = 1'($urandom_range(0, 1));
      rdy_rand = 1'($urandom_range(0, 1));
      burst = 32'($urandom_range(0, 700));
      start_run(le, 64'($urandom_range(1, 8)), burst, 32'($urandom_range(0, 300)),
                32'($urandom_range(0, 600)), {2'($urandom_range(0, 3)), 32'($urandom)},
                5'($urandom_range(0, 31)), beats_of(burst) + int'($urandom_range(0, 10)), 1'b1);
      wait_done("random", 3000);
    end
    rdy_rand = 1'b0;
    err_pct = 0;

    wait_cycles(30);
    check_eq("left_ar", 96'(exp_ar_q.size()), 96'd0);
    check_eq("left_lat", 96'(exp_lat_q.size()), 96'd0);
    check_eq("left_done", 96'(exp_done_q.size()), 96'd0);
    check_eq("left_resp", 96'(pend_q.size()), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
